mul_iter: RTL



---
 rtl/milano_mul_pkg.sv | 20 ++
 rtl/mul_iter.sv | 117 +++++++++++
 2 files changed

// File: rtl/milano_mul_pkg.sv
// Shared types for the Milano iterative multiplier: op encoding, FSM states, latency.
package milano_mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    NEG  = 2'b10,
    DONE = 2'b11
  } mul_state_e;

  localparam int unsigned MUL_LATENCY = 34;

endpackage

// File: rtl/mul_iter.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are sign-conditioned to magnitudes, multiplied unsigned, then negated once.
module mul_iter
  import milano_mul_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mul_start,
  input  logic [1:0]      mul_op,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  output logic [XLEN-1:0] result,
  output logic            mul_done,
  output logic            mul_busy
);

  localparam int unsigned CW = $clog2(XLEN);

  mul_state_e          state_q, state_d;
  mul_op_e             op_q, op_d;
  logic                res_neg_q, res_neg_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  mul_op_e             op_in;
  logic                a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;

  // Sign conditioning of the raw operands; only consumed on the accept edge.
  always_comb begin
    op_in = mul_op_e'(mul_op);
    a_neg = multiplicand[XLEN-1] & ((op_in == MULH) | (op_in == MULHSU));
    b_neg = multiplier[XLEN-1] & (op_in == MULH);
    a_mag = a_neg ? (~multiplicand + 1'b1) : multiplicand;
    b_mag = b_neg ? (~multiplier + 1'b1) : multiplier;
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    res_neg_d = res_neg_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mul_start) begin
          op_d      = op_in;
          res_neg_d = a_neg ^ b_neg;
          mcand_d   = {{XLEN{1'b0}}, a_mag};
          mplier_d  = b_mag;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        // Multiplicand shifts left while the multiplier shifts right, so bit 0
        // of mplier_q always selects the partial product for this edge.
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) state_d = NEG;
      end
      NEG: begin
        if (res_neg_q) acc_d = ~acc_q + 1'b1;
        state_d = DONE;
      end
      DONE: begin
        result_d = (op_q == MUL) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= MUL;
      res_neg_q <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      res_neg_q <= res_neg_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign result   = result_q;
  assign mul_done = done_q;
  assign mul_busy = (state_q != IDLE);

endmodule
